mem_stage_sram: RTL and testbench

- MEM stage of the 5-stage ARM pipeline, between the EXE stage register and the MEM/WB register.
- Uses the EXE-register address (ALU_result) and store data (ST_val) to run 32-bit loads/stores against an external 16-bit asynchronous SRAM, as two half-word accesses.
- Drives ready low while an access is in flight. The top level uses ~ready as the pipeline freeze and as the MEM/WB load enable.

---
 rtl/mem_stage_sram_pkg.sv | 7 +
 rtl/mem_stage_sram_wait_counter.sv | 18 +
 rtl/mem_stage_sram.sv | 90 +++++++++
 tb/tb_mem_stage_sram.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg: shared state encoding and SRAM geometry for the MEM stage.
package mem_stage_sram_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
endpackage

// File: rtl/mem_stage_sram_wait_counter.sv
// sram_wait_counter: per-phase cycle counter; o_last flags the final cycle of a half-word access.
module sram_wait_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_count,
  output logic       o_last
);
  logic [3:0] r_count;
  always_ff @(posedge clk)
    if (rst || i_clr) r_count <= '0;
    else if (i_en) r_count <= r_count + 4'd1;
  assign o_count = r_count;
  assign o_last = r_count == 4'(ACCESS_CYCLES - 1);
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage running 32-bit loads/stores as two half-word accesses on a 16-bit async SRAM.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DATA_MEM_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_result,
  input  logic [31:0]            ST_val,
  output logic [31:0]            mem_rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] SRAM_WDATA,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_DQ_OE,
  input  logic [SRAM_DATA_W-1:0] SRAM_RDATA
);
  state_t      r_state;
  logic        r_wr;
  logic [16:0] r_widx;
  logic [15:0] r_st_hi;
  logic [3:0]  w_cnt;
  logic        w_last;
  logic        w_req;
  logic        w_wr;
  logic        w_phase;
  logic        w_penult;
  logic [31:0] w_off;
  logic        w_unused;
  assign w_req    = MEM_R_EN | MEM_W_EN;
  assign w_wr     = MEM_W_EN & ~MEM_R_EN;
  assign w_off    = ALU_result - BASE_ADDR;
  assign w_phase  = (r_state == LO) || (r_state == HI);
  assign w_penult = w_cnt == 4'(ACCESS_CYCLES - 2);
  assign ready    = (r_state == IDLE && !w_req) || r_state == DONE;
  assign w_unused = &{1'b0, w_off[31:19], w_off[1:0]};
  sram_wait_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == IDLE || w_last),
    .i_en    (w_phase),
    .o_count (w_cnt),
    .o_last  (w_last)
  );
  // SRAM pins are registered one state ahead so they are glitch-free for the whole phase;
  // WE_N rises one cycle early to give address/data hold on the final cycle.
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_widx      <= '0;
      r_st_hi     <= '0;
      mem_rd_data <= '0;
      SRAM_ADDR   <= '0;
      SRAM_WDATA  <= '0;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_OE  <= 1'b0;
    end else
      case (r_state)
        IDLE: if (w_req) begin
          r_state    <= LO;
          r_wr       <= w_wr;
          r_widx     <= w_off[18:2];
          r_st_hi    <= ST_val[31:16];
          SRAM_ADDR  <= {w_off[18:2], 1'b0};
          SRAM_WDATA <= ST_val[15:0];
          SRAM_WE_N  <= ~w_wr;
          SRAM_DQ_OE <= w_wr;
        end
        LO: if (w_last) begin
          r_state    <= HI;
          SRAM_ADDR  <= {r_widx, 1'b1};
          SRAM_WDATA <= r_st_hi;
          SRAM_WE_N  <= ~r_wr;
          SRAM_DQ_OE <= r_wr;
          if (!r_wr) mem_rd_data[15:0] <= SRAM_RDATA;
        end else if (w_penult) SRAM_WE_N <= 1'b1;
        HI: if (w_last) begin
          r_state    <= DONE;
          SRAM_WE_N  <= 1'b1;
          SRAM_DQ_OE <= 1'b0;
          if (!r_wr) mem_rd_data[31:16] <= SRAM_RDATA;
        end else if (w_penult) SRAM_WE_N <= 1'b1;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: scoreboard bench for mem_stage_sram with ACCESS_CYCLES 2 (inst 0) and 4 (inst 1).
module tb_mem_stage_sram;
  typedef struct {int inst; int low; logic rd; logic [31:0] data;} acc_t;
  typedef struct {int inst; logic [17:0] a; logic [15:0] d;} wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], r_en[2], w_en[2], rdy[2], we_n[2], oe[2];
  logic [31:0] alu[2], st[2], rd[2];
  logic [17:0] sa[2];
  logic [15:0] swd[2], srd[2];
  logic [15:0] sram[2][256];
  acc_t aq[$];
  wr_t  wq[$];
  int errs = 0, checks = 0;
  int lowcnt[2] = '{0, 0};
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : u
      mem_stage_sram #(.ACCESS_CYCLES(g == 0 ? 2 : 4)) dut (
        .clk(clk), .rst(rst[g]), .MEM_R_EN(r_en[g]), .MEM_W_EN(w_en[g]),
        .ALU_result(alu[g]), .ST_val(st[g]), .mem_rd_data(rd[g]), .ready(rdy[g]),
        .SRAM_ADDR(sa[g]), .SRAM_WDATA(swd[g]), .SRAM_WE_N(we_n[g]),
        .SRAM_DQ_OE(oe[g]), .SRAM_RDATA(srd[g])
      );
      assign srd[g] = sram[g][sa[g][7:0]];
    end
  endgenerate
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_wr(int k, logic [17:0] a, logic [15:0] d, int n);
    wr_t w;
    w.inst = k; w.a = a; w.d = d;
    for (int i = 0; i < n; i++) wq.push_back(w);
  endtask
  task automatic exp_acc(int k, int low, logic r, logic [31:0] d);
    acc_t a;
    a.inst = k; a.low = low; a.rd = r; a.data = d;
    aq.push_back(a);
  endtask
  task automatic access(int k, logic r, logic w, logic [31:0] a, logic [31:0] d);
    bit done;
    done = 0;
    r_en[k] = r; w_en[k] = w; alu[k] = a; st[k] = d;
    for (int n = 0; n < 100 && !done; n++) begin
      tick();
      if (rdy[k]) done = 1;
    end
    if (!done) begin
      checks++; errs++;
      $display("FAIL access_timeout: inst %0d ready never returned high", k);
    end
  endtask
  task automatic idle(int k, int n, logic [31:0] hold);
    r_en[k] = 0; w_en[k] = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_ready", rdy[k], 1);
      chk("rd_hold", rd[k], hold);
    end
  endtask
  // Monitor: SRAM model writes, write scoreboard, and per-access scoreboard popped at DONE.
  always @(negedge clk) begin
    wr_t w;
    acc_t a;
    for (int k = 0; k < 2; k++) begin
      if (!we_n[k]) begin
        sram[k][sa[k][7:0]] = swd[k];
        if (wq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_write: inst %0d addr %h data %h", k, sa[k], swd[k]);
        end else begin
          w = wq.pop_front();
          chk("wr_inst", k, w.inst);
          chk("wr_addr", 32'(sa[k]), 32'(w.a));
          chk("wr_data", 32'(swd[k]), 32'(w.d));
          chk("wr_oe", oe[k], 1);
        end
      end
      if (rst[k]) lowcnt[k] = 0;
      else if (!rdy[k]) lowcnt[k]++;
      else if (lowcnt[k] != 0) begin
        if (aq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_done: inst %0d low for %0d cycles", k, lowcnt[k]);
        end else begin
          a = aq.pop_front();
          chk("acc_inst", k, a.inst);
          chk("ready_low_cycles", lowcnt[k], a.low);
          if (a.rd) chk("rd_data", rd[k], a.data);
        end
        lowcnt[k] = 0;
      end
    end
  end
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) sram[k][i] = 16'h0;
      rst[k] = 1; r_en[k] = 0; w_en[k] = 0; alu[k] = 0; st[k] = 0;
    end
    sram[0][0] = 16'h1234; sram[0][1] = 16'h5678;
    sram[1][2] = 16'h0BAD; sram[1][3] = 16'hF00D;
    tick(); tick();
    chk("rst_ready", rdy[0], 1);
    chk("rst_we_n", we_n[0], 1);
    chk("rst_oe", oe[0], 0);
    chk("rst_rd", rd[0], 0);
    chk("rst_addr", 32'(sa[0]), 0);
    rst[0] = 0; rst[1] = 0;
    idle(0, 2, 0);
    // store 0xDEADBEEF at 1032 -> half-words 4,5
    exp_wr(0, 18'd4, 16'hBEEF, 1);
    exp_wr(0, 18'd5, 16'hDEAD, 1);
    exp_acc(0, 5, 0, 0);
    access(0, 0, 1, 32'd1032, 32'hDEADBEEF);
    idle(0, 2, 0);
    exp_acc(0, 5, 1, 32'hDEADBEEF);
    access(0, 1, 0, 32'd1032, 32'h0);
    idle(0, 3, 32'hDEADBEEF);
    // both enables high: read wins, no write expected
    exp_acc(0, 5, 1, 32'h56781234);
    access(0, 1, 1, 32'd1024, 32'hFFFFFFFF);
    idle(0, 1, 32'h56781234);
    // reset during HI of a store, request held -> restart from LO
    exp_wr(0, 18'd8, 16'hF00D, 1);
    exp_wr(0, 18'd9, 16'hCAFE, 1);
    exp_wr(0, 18'd8, 16'hF00D, 1);
    exp_wr(0, 18'd9, 16'hCAFE, 1);
    exp_acc(0, 5, 0, 0);
    r_en[0] = 0; w_en[0] = 1; alu[0] = 32'd1040; st[0] = 32'hCAFEF00D;
    tick(); tick(); tick();
    rst[0] = 1;
    tick();
    chk("midrst_ready", rdy[0], 0);
    chk("midrst_we_n", we_n[0], 1);
    chk("midrst_oe", oe[0], 0);
    chk("midrst_rd", rd[0], 0);
    chk("midrst_addr", 32'(sa[0]), 0);
    rst[0] = 0;
    access(0, 0, 1, 32'd1040, 32'hCAFEF00D);
    idle(0, 1, 0);
    // ACCESS_CYCLES=4: back-to-back load then store
    exp_acc(1, 9, 1, 32'hF00D0BAD);
    access(1, 1, 0, 32'd1028, 32'h0);
    exp_wr(1, 18'd6, 16'h5678, 3);
    exp_wr(1, 18'd7, 16'h1234, 3);
    exp_acc(1, 9, 0, 0);
    access(1, 0, 1, 32'd1036, 32'h12345678);
    idle(1, 2, 32'hF00D0BAD);
    tick(); tick();
    checks++;
    if (aq.size() != 0 || wq.size() != 0) begin
      errs++;
      $display("FAIL leftover_expectations: got %0d accesses %0d writes pending, expected 0", aq.size(), wq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
